// File: rtl/dff_pkg.sv
// Shared constants and a ceiling-log2 helper for the delay line and its stages.
// Constant-only package: no state, no timing.
package dff_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Smallest r with 2**r >= n; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// One delay-line stage: data register plus valid bit, one-edge latency.
// No backpressure; en holds the stage, clr_v drops valid while data holds.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_v,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] r_dat;
    logic             r_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dat <= RESET_VAL;
            r_vld <= 1'b0;
        end else if (clr_v) begin
            r_vld <= 1'b0;
        end else if (en) begin
            r_dat <= d;
            r_vld <= d_valid;
        end
    end

    assign q       = r_dat;
    assign q_valid = r_vld;

endmodule

// File: rtl/delay_line_dff.sv
// Enable-gated shift register of DEPTH (data, valid) stages with a tap mux and occupancy count.
// Latency DEPTH enabled edges; no backpressure, en=0 stalls every stage in place.
module delay_line_dff
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              TW        = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1,
    localparam int              CW        = clog2(DEPTH + 1)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    occ
);

    logic [WIDTH-1:0] w_din   [DEPTH];
    logic             w_vin   [DEPTH];
    logic [WIDTH-1:0] w_stage [DEPTH];
    logic             w_vld   [DEPTH];
    logic [CW-1:0]    r_occ;
    logic [WIDTH-1:0] w_tap_q;
    logic             w_tap_valid;

    assign w_din[0] = d;
    assign w_vin[0] = d_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g > 0) begin : g_link
            assign w_din[g] = w_stage[g-1];
            assign w_vin[g] = w_vld[g-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr_v   (flush),
            .d       (w_din[g]),
            .d_valid (w_vin[g]),
            .q       (w_stage[g]),
            .q_valid (w_vld[g])
        );
    end

    // Entry and exit are applied in one update so a simultaneous push and drop leaves occ unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_occ <= '0;
        end else if (en) begin
            r_occ <= r_occ + CW'(d_valid) - CW'(w_vld[DEPTH-1]);
        end
    end

    // Out-of-range selects fall through to the reset value; a single stage ignores tap_sel.
    always_comb begin
        w_tap_q     = RESET_VAL;
        w_tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DEPTH == 1 || int'(tap_sel) == i) begin
                w_tap_q     = w_stage[i];
                w_tap_valid = w_vld[i];
            end
        end
    end

    assign q         = w_stage[DEPTH-1];
    assign q_valid   = w_vld[DEPTH-1];
    assign tap_q     = w_tap_q;
    assign tap_valid = w_tap_valid;
    assign occ       = r_occ;

endmodule

// File: tb/tb_delay_line_dff.sv
// Three delay lines (DEPTH 4 / 1 / 5) share one stimulus stream; a queue-based model
// predicts every cycle and a monitor compares at the falling edge.
module tb_delay_line_dff;

    typedef struct {
        logic [7:0] dat;
        logic       vld;
    } ent_t;

    typedef ent_t pipe_t[$];

    typedef struct {
        logic [7:0] q   [3];
        logic       qv  [3];
        int         occ [3];
        logic [7:0] tq  [3];
        logic       tv  [3];
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_valid = 1'b0;
    logic [1:0] tap_a = 2'd0;
    logic [0:0] tap_b = 1'b0;
    logic [2:0] tap_c = 3'd0;

    logic [7:0] q_a, q_b, q_c, tq_a, tq_b, tq_c;
    logic       qv_a, qv_b, qv_c, tv_a, tv_b, tv_c;
    logic [2:0] occ_a;
    logic [0:0] occ_b;
    logic [2:0] occ_c;

    int checks = 0;
    int errors = 0;

    pipe_t pa, pb, pc;
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    delay_line_dff #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_a (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(tap_a), .q(q_a), .q_valid(qv_a), .tap_q(tq_a), .tap_valid(tv_a), .occ(occ_a)
    );

    delay_line_dff #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_b (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(tap_b), .q(q_b), .q_valid(qv_b), .tap_q(tq_b), .tap_valid(tv_b), .occ(occ_b)
    );

    delay_line_dff #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h00)) u_c (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(tap_c), .q(q_c), .q_valid(qv_c), .tap_q(tq_c), .tap_valid(tv_c), .occ(occ_c)
    );

    // Model: the pipeline is a list of entries, newest first, always exactly depth long.
    function automatic pipe_t advance(pipe_t p, int depth, logic [7:0] rv,
                                      logic r, logic e, logic f, logic [7:0] dd, logic dv);
        pipe_t n;
        n = p;
        if (r) begin
            n = {};
            for (int i = 0; i < depth; i++) n.push_back(ent_t'{dat: rv, vld: 1'b0});
        end else if (f) begin
            foreach (n[i]) n[i].vld = 1'b0;
        end else if (e) begin
            n.push_front(ent_t'{dat: dd, vld: dv});
            n.delete(depth);
        end
        return n;
    endfunction

    function automatic int popcount(pipe_t p);
        int c;
        c = 0;
        foreach (p[i]) c += int'(p[i].vld);
        return c;
    endfunction

    function automatic ent_t tap_of(pipe_t p, int depth, int sel, logic [7:0] rv);
        if (depth == 1) return p[0];
        if (sel < depth) return p[sel];
        return ent_t'{dat: rv, vld: 1'b0};
    endfunction

    task automatic fill(inout exp_t x, input int k, input pipe_t p, input int depth,
                        input int sel, input logic [7:0] rv);
        ent_t t;
        t        = tap_of(p, depth, sel, rv);
        x.q[k]   = p[depth-1].dat;
        x.qv[k]  = p[depth-1].vld;
        x.occ[k] = popcount(p);
        x.tq[k]  = t.dat;
        x.tv[k]  = t.vld;
    endtask

    task automatic step(input logic r, input logic e, input logic f, input logic [7:0] dd,
                        input logic dv, input int sa, input int sc);
        exp_t x;
        rst     = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        tap_a   = 2'(sa);
        tap_c   = 3'(sc);
        tap_b   = 1'($urandom_range(0, 1));
        @(posedge clk);
        pa = advance(pa, 4, 8'h5A, r, e, f, dd, dv);
        pb = advance(pb, 1, 8'h00, r, e, f, dd, dv);
        pc = advance(pc, 5, 8'h00, r, e, f, dd, dv);
        fill(x, 0, pa, 4, sa, 8'h5A);
        fill(x, 1, pb, 1, 0, 8'h00);
        fill(x, 2, pc, 5, sc, 8'h00);
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int k, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, req, $time);
        end
    endtask

    // Monitor: one prediction is queued per edge and consumed at the following falling edge.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.q   = '{q_a, q_b, q_c};
                a.qv  = '{qv_a, qv_b, qv_c};
                a.occ = '{int'(occ_a), int'(occ_b), int'(occ_c)};
                a.tq  = '{tq_a, tq_b, tq_c};
                a.tv  = '{tv_a, tv_b, tv_c};
                for (int k = 0; k < 3; k++) begin
                    chk("q",         k, int'(a.q[k]),  int'(e.q[k]));
                    chk("q_valid",   k, int'(a.qv[k]), int'(e.qv[k]));
                    chk("occ",       k, a.occ[k],      e.occ[k]);
                    chk("tap_q",     k, int'(a.tq[k]), int'(e.tq[k]));
                    chk("tap_valid", k, int'(a.tv[k]), int'(e.tv[k]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        // reset, including a reset with en=1 and flush=1 to check priority
        step(1, 0, 0, 8'h00, 0, 0, 0);
        step(1, 1, 1, 8'h77, 1, 0, 0);

        // basic latency: 0x11..0x55 then keep valid data flowing
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 8'(i * 8'h11), 1, 3, 4);
        for (int i = 0; i < 3; i++)  step(0, 1, 0, 8'(8'h60 + i), 1, i, i);

        // stall with 0xA1,0xA2 in flight
        step(1, 0, 0, 8'h00, 0, 0, 0);
        step(0, 1, 0, 8'hA1, 1, 1, 1);
        step(0, 1, 0, 8'hA2, 1, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'(8'hE0 + i), 1, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00, 0, 3, 4);

        // bubbles and tap scan, including out-of-range selects on the DEPTH=5 line
        step(1, 0, 0, 8'h00, 0, 0, 0);
        step(0, 1, 0, 8'h01, 1, 0, 0);
        step(0, 1, 0, 8'h02, 0, 0, 0);
        step(0, 1, 0, 8'h03, 1, 0, 0);
        step(0, 1, 0, 8'h04, 0, 0, 0);
        for (int s = 0; s < 8; s++) step(0, 0, 0, 8'h99, 1, s % 4, s);

        // full pipeline flushed with en=1 and valid 0xFF presented
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hC0 + i), 1, 2, 2);
        step(0, 1, 1, 8'hFF, 1, 3, 4);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00, 0, 3, 4);

        // reset with full pipeline and en=1, then first capture after reset
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'hD0 + i), 1, 3, 4);
        step(1, 1, 0, 8'hEE, 1, 3, 4);
        step(0, 1, 0, 8'h3C, 1, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 0, 8'h00, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, 8'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
